fft_out_serializer: RTL and testbench
=====================================

Name: fft_out_serializer

Overview:
- Stage directly downstream of the final 4-to-2 DFT/butterfly stage.
- Captures one full parallel frame of N complex results (the 16 groups × 2 outputs fa0..fp1) in a single handshake.
- Streams the frame out one complex sample per cycle over a valid/ready interface, with optional rounding right-shift, index tag and last flag.
- Converts the wide combinational FFT output into a narrow stream for the testbench scoreboard and downstream logic.

Parameters:
- N, 32, complex samples per frame; power of two, 4..64.
- IDX_W, 5, width of sample index; must equal log2(N).
- OUT_W, 8, signed width of each real/imag component, in and out.
- OUT_SHIFT, 0, arithmetic right shift with round-half-up applied on output; 0..OUT_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  parallel frame present.
- in_ready  out  1  block can accept a frame this cycle.
- in_r_bus  in  N*OUT_W  packed real parts; entry k at [k*OUT_W +: OUT_W], k=2*g+n (g=group a..p, n=0/1).
- in_i_bus  in  N*OUT_W  packed imaginary parts, same packing.
- out_valid  out  1  output sample valid.
- out_ready  in  1  consumer accepts sample.
- out_r  out  OUT_W  signed real part.
- out_i  out  OUT_W  signed imaginary part.
- out_idx  out  IDX_W  output beat number 0..N-1 within the frame.
- out_last  out  1  high with beat N-1.

Behaviour:
- Reset (async assert, sync deassert at the block boundary):
  - state=IDLE, beat counter=0.
  - out_valid=0, out_r=0, out_i=0, out_idx=0, out_last=0.
  - Frame storage is not reset.
- FSM IDLE:
  - in_ready=1.
  - On in_valid at an edge: latch both buses into frame regs, counter=0, out_valid<=1, go to STREAM.
  - Latency: first beat is valid on the edge after capture (1 cycle).
- FSM STREAM:
  - out_r/out_i/out_idx/out_last are registered and held stable while out_valid && !out_ready.
  - On out_valid && out_ready with counter<N-1: counter+1; next sample presented on the following cycle.
- Last beat (counter==N-1, out_last=1) taken by out_ready:
  - in_ready=1 combinationally in this cycle.
  - If in_valid is also high: capture the new frame, counter=0, out_valid stays 1, stay in STREAM. This gives back-to-back frames with zero bubble.
  - Otherwise: out_valid<=0, go to IDLE.
- in_ready=0 at all other times in STREAM. in_valid during STREAM is ignored; the frame source must hold its data.
- Sample select: beat j reads entry j (natural entry order) unless the optional feature is enabled.
- Arithmetic:
  - OUT_SHIFT=0: pass-through.
  - OUT_SHIFT=S>0: y = (x + 2^(S-1)) >>> S, computed at OUT_W+1 bits and truncated to OUT_W. The result always fits, so no saturation is needed.
- out_idx = counter; out_last = (counter==N-1).
- Reset mid-frame: the frame is abandoned, outputs clear immediately, and in_ready=1 after deassert.

Optional Feature:
- Macro FFT_SER_BITREV_EN.
- Defined: beat j reads entry bitrev_IDX_W(j), restoring natural frequency order. Example, N=32: beat 1 reads entry 16, beat 2 reads entry 8, beat 31 reads entry 31. out_idx still reports j.
- Undefined: beat j reads entry j. No reorder logic is compiled.

Test Plan:
- Reset/idle: hold rst_n=0, then release with in_valid=0. Expect out_valid=0, out_r=out_i=0, in_ready=1 for 10 cycles.
- Single frame: entry k = (r=k, i=-k), out_ready=1. Expect 32 beats starting 1 cycle after capture, beat j = (j,-j), out_last only on beat 31, then out_valid=0 and in_ready=1. With FFT_SER_BITREV_EN, beat 1 = (16,-16) and beat 3 = (24,-24).
- Backpressure: same frame, out_ready toggling 1,0,0,1,... Each beat is held stable while stalled; beat order is unchanged; no beats are lost or duplicated.
- Back-to-back: frame A (all r=1), then frame B (all r=2) with in_valid high at A's last beat. Expect B beat 0 on the very next cycle, out_valid never drops, 64 beats total.
- Rounding: OUT_SHIFT=2, with entries 127, -128, 6, -6, 5. Expect outputs 32, -32, 2, -1, 1.
- Reset mid-frame: assert rst_n=0 at beat 10. Expect out_valid=0 immediately. After release, a new frame streams starting at out_idx=0 with correct data.

Source files
------------

// File: rtl/fft_out_serializer_if.sv
// Frame-in / sample-out handshake bundle for fft_out_serializer.
// The serializer connects to the slave modport; the frame source and the sample sink connect to master.
interface fft_out_serializer_if #(
    parameter int N     = 32,
    parameter int IDX_W = 5,
    parameter int OUT_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [N*OUT_W-1:0]      in_r_bus;
    logic [N*OUT_W-1:0]      in_i_bus;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_r;
    logic signed [OUT_W-1:0] out_i;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_last;

    modport slave (
        input  in_valid, in_r_bus, in_i_bus, out_ready,
        output in_ready, out_valid, out_r, out_i, out_idx, out_last
    );

    modport master (
        output in_valid, in_r_bus, in_i_bus, out_ready,
        input  in_ready, out_valid, out_r, out_i, out_idx, out_last
    );
endinterface

// File: rtl/fft_out_serializer.sv
// Captures a parallel frame of N complex FFT results and streams it out one sample per beat.
// Define FFT_SER_BITREV_EN to read entries in bit-reversed order (natural frequency order).
module fft_out_serializer #(
    parameter int N         = 32,
    parameter int IDX_W     = 5,
    parameter int OUT_W     = 8,
    parameter int OUT_SHIFT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    fft_out_serializer_if.slave bus
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam int HALF_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
    localparam logic signed [OUT_W:0] HALF = (OUT_W+1)'((OUT_SHIFT > 0) ? (1 << HALF_SH) : 0);

    state_t                  state_q, state_d;
    logic                    capture, advance, in_ready_c;
    logic [IDX_W-1:0]        cnt_q, nxt_idx, ent;
    logic [N*OUT_W-1:0]      frame_r, frame_i;
    logic signed [OUT_W-1:0] raw_r, raw_i, r_q, i_q;
    logic                    last_q;

    // Round-half-up arithmetic shift; one guard bit keeps +HALF from overflowing.
    function automatic logic signed [OUT_W-1:0] shape(input logic signed [OUT_W-1:0] x);
        logic signed [OUT_W:0] t;
        t = $signed({x[OUT_W-1], x}) + HALF;
        return OUT_W'(t >>> OUT_SHIFT);
    endfunction

`ifdef FFT_SER_BITREV_EN
    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] j);
        logic [IDX_W-1:0] r;
        for (int b = 0; b < IDX_W; b++) r[b] = j[IDX_W-1-b];
        return r;
    endfunction
    assign ent = bitrev(nxt_idx);
`else
    assign ent = nxt_idx;
`endif

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    capture = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (bus.out_ready) begin
                    if (last_q) begin
                        // Last beat leaving frees the frame regs for a bubble-free reload.
                        in_ready_c = 1'b1;
                        if (bus.in_valid) capture = 1'b1;
                        else              state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The first beat of a new frame comes straight off the bus, since frame regs load on the same edge.
    always_comb begin
        nxt_idx = capture ? '0 : cnt_q + IDX_W'(1);
        raw_r   = capture ? bus.in_r_bus[OUT_W-1:0] : frame_r[ent*OUT_W +: OUT_W];
        raw_i   = capture ? bus.in_i_bus[OUT_W-1:0] : frame_i[ent*OUT_W +: OUT_W];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            i_q     <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture || advance) begin
                cnt_q  <= nxt_idx;
                r_q    <= shape(raw_r);
                i_q    <= shape(raw_i);
                last_q <= (nxt_idx == IDX_W'(N-1));
            end
        end
    end

    // NOTE: frame storage has no reset; it is always written before being read.
    always_ff @(posedge clk) begin
        if (capture) begin
            frame_r <= bus.in_r_bus;
            frame_i <= bus.in_i_bus;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == STREAM);
    assign bus.out_r     = r_q;
    assign bus.out_i     = i_q;
    assign bus.out_idx   = cnt_q;
    assign bus.out_last  = last_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Scoreboard bench for fft_out_serializer: a pass-through instance and an OUT_SHIFT=2 instance.
// Expected beats are queued at issue time; negedge monitors pop and compare on each transfer.
module tb_fft_out_serializer;

    localparam int N     = 32;
    localparam int IDX_W = 5;
    localparam int OUT_W = 8;

    typedef struct packed {
        logic signed [OUT_W-1:0] r;
        logic signed [OUT_W-1:0] i;
        logic [IDX_W-1:0]        idx;
        logic                    last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic iv_m, iv_s, out_ready;
    logic [N*OUT_W-1:0] r_bus, i_bus;
    bit   bp_en = 1'b0;
    int   bp_phase = 0;
    bit   b2b_watch = 1'b0;

    int total = 0;
    int bad = 0;
    int beats_m = 0;

    beat_t q_m[$];
    beat_t q_s[$];

    logic signed [OUT_W-1:0] ent_r[N], ent_i[N], exp_r[N], exp_i[N];

    always #5 clk = ~clk;

    fft_out_serializer_if #(.N(N), .IDX_W(IDX_W), .OUT_W(OUT_W)) fm ();
    fft_out_serializer_if #(.N(N), .IDX_W(IDX_W), .OUT_W(OUT_W)) fs ();

    assign fm.in_valid  = iv_m;
    assign fm.in_r_bus  = r_bus;
    assign fm.in_i_bus  = i_bus;
    assign fm.out_ready = out_ready;
    assign fs.in_valid  = iv_s;
    assign fs.in_r_bus  = r_bus;
    assign fs.in_i_bus  = i_bus;
    assign fs.out_ready = out_ready;

    fft_out_serializer #(.N(N), .IDX_W(IDX_W), .OUT_W(OUT_W), .OUT_SHIFT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(fm)
    );
    fft_out_serializer #(.N(N), .IDX_W(IDX_W), .OUT_W(OUT_W), .OUT_SHIFT(2)) u_dut_sh (
        .clk(clk), .rst_n(rst_n), .bus(fs)
    );

    task automatic check(input string name, input logic signed [31:0] got, input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic int map_idx(input int j);
`ifdef FFT_SER_BITREV_EN
        int r = 0;
        for (int b = 0; b < IDX_W; b++) if (j[b]) r |= 1 << (IDX_W-1-b);
        return r;
`else
        return j;
`endif
    endfunction

    task automatic fill_pass();
        for (int j = 0; j < N; j++) begin
            exp_r[j] = ent_r[map_idx(j)];
            exp_i[j] = ent_i[map_idx(j)];
        end
    endtask

    task automatic compare_beat(input bit sh, input beat_t got);
        beat_t e;
        string p = sh ? "shift" : "main";
        if (sh ? (q_s.size() == 0) : (q_m.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL %s_extra_beat got idx=%0d exp=none", p, got.idx);
        end else begin
            e = sh ? q_s.pop_front() : q_m.pop_front();
            check({p, "_r"},    got.r,    e.r);
            check({p, "_i"},    got.i,    e.i);
            check({p, "_idx"},  got.idx,  e.idx);
            check({p, "_last"}, got.last, e.last);
        end
    endtask

    // Main monitor: scoreboard compare, stall-hold check and back-to-back continuity.
    bit    stalled_prev = 1'b0;
    beat_t held;
    always @(negedge clk) begin
        beat_t cur;
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            cur = '{r: fm.out_r, i: fm.out_i, idx: fm.out_idx, last: fm.out_last};
            if (stalled_prev) begin
                check("hold_valid", fm.out_valid, 1);
                check("hold_r",     cur.r,        held.r);
                check("hold_i",     cur.i,        held.i);
                check("hold_idx",   cur.idx,      held.idx);
            end
            if (b2b_watch) check("b2b_valid", fm.out_valid, 1);
            stalled_prev = fm.out_valid && !fm.out_ready;
            held = cur;
            if (fm.out_valid && fm.out_ready) begin
                beats_m++;
                compare_beat(1'b0, cur);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && fs.out_valid && fs.out_ready)
            compare_beat(1'b1, '{r: fs.out_r, i: fs.out_i, idx: fs.out_idx, last: fs.out_last});
    end

    // Sink: always ready, or the 1,0,0 repeating pattern when backpressure is on.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                out_ready = (bp_phase % 3 == 0);
                bp_phase++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic send(input bit sh);
        bit got = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (sh) q_s.push_back('{r: exp_r[j], i: exp_i[j], idx: IDX_W'(j), last: (j == N-1)});
            else    q_m.push_back('{r: exp_r[j], i: exp_i[j], idx: IDX_W'(j), last: (j == N-1)});
        end
        for (int k = 0; k < N; k++) begin
            r_bus[k*OUT_W +: OUT_W] = ent_r[k];
            i_bus[k*OUT_W +: OUT_W] = ent_i[k];
        end
        if (sh) iv_s = 1'b1; else iv_m = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (sh ? fs.in_ready : fm.in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL send_timeout got in_ready=0 exp=1");
        end
        @(posedge clk);
        #1;
        iv_m = 1'b0;
        iv_s = 1'b0;
    endtask

    task automatic drain(input bit sh);
        bit done = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            if (sh ? (q_s.size() == 0) : (q_m.size() == 0)) begin
                done = 1'b1;
                break;
            end
        end
        b2b_watch = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got pending=%0d exp=0", sh ? q_s.size() : q_m.size());
        end
        @(negedge clk);
        check(sh ? "shift_idle_valid" : "main_idle_valid", sh ? fs.out_valid : fm.out_valid, 0);
        check(sh ? "shift_idle_ready" : "main_idle_ready", sh ? fs.in_ready : fm.in_ready, 1);
    endtask

    task automatic ramp_frame();
        for (int k = 0; k < N; k++) begin
            ent_r[k] = OUT_W'(k);
            ent_i[k] = OUT_W'(-k);
        end
        fill_pass();
    endtask

    initial begin
        int start_beats;
        bit seen;
        logic signed [OUT_W-1:0] hr_r[5], hr_i[5], hx_r[5], hx_i[5];

        rst_n = 1'b0;
        iv_m  = 1'b0;
        iv_s  = 1'b0;
        r_bus = '0;
        i_bus = '0;

        // Reset and idle
        #2;
        check("rst_valid", fm.out_valid, 0);
        #30;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_valid", fm.out_valid, 0);
            check("idle_r",     fm.out_r,     0);
            check("idle_i",     fm.out_i,     0);
            check("idle_ready", fm.in_ready,  1);
        end
        @(posedge clk);
        #1;

        // Single frame (k, -k), one-cycle latency
        ramp_frame();
        send(1'b0);
        check("lat_valid", fm.out_valid, 1);
        check("lat_idx",   fm.out_idx,   0);
        drain(1'b0);

        // Backpressure
        @(posedge clk);
        #1;
        bp_phase = 0;
        bp_en = 1'b1;
        send(1'b0);
        drain(1'b0);
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back frames A then B
        start_beats = beats_m;
        for (int k = 0; k < N; k++) begin
            ent_r[k] = 8'sd1;
            ent_i[k] = OUT_W'(k);
        end
        fill_pass();
        send(1'b0);
        b2b_watch = 1'b1;
        for (int k = 0; k < N; k++) begin
            ent_r[k] = 8'sd2;
            ent_i[k] = OUT_W'(-k);
        end
        fill_pass();
        send(1'b0);
        drain(1'b0);
        check("b2b_beats", beats_m - start_beats, 2*N);

        // Rounding on the OUT_SHIFT=2 instance; remaining entries are zero and round to zero
        hx_r = '{8'sd127, -8'sd128, 8'sd6, -8'sd6, 8'sd5};
        hr_r = '{8'sd32,  -8'sd32,  8'sd2, -8'sd1, 8'sd1};
        hx_i = '{-8'sd127, 8'sd3, -8'sd1, -8'sd5, 8'sd126};
        hr_i = '{-8'sd32,  8'sd1,  8'sd0, -8'sd1, 8'sd32};
        for (int k = 0; k < N; k++) begin
            ent_r[k] = (k < 5) ? hx_r[k] : 8'sd0;
            ent_i[k] = (k < 5) ? hx_i[k] : 8'sd0;
        end
        for (int j = 0; j < N; j++) begin
            exp_r[j] = (map_idx(j) < 5) ? hr_r[map_idx(j)] : 8'sd0;
            exp_i[j] = (map_idx(j) < 5) ? hr_i[map_idx(j)] : 8'sd0;
        end
        @(posedge clk);
        #1;
        send(1'b1);
        drain(1'b1);

        // Reset while beat 10 is presented
        @(posedge clk);
        #1;
        ramp_frame();
        send(1'b0);
        seen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #2;
            if (fm.out_valid && fm.out_idx == IDX_W'(10)) begin
                seen = 1'b1;
                break;
            end
        end
        check("midrst_reached_beat10", seen, 1);
        rst_n = 1'b0;
        q_m.delete();
        #1;
        check("midrst_valid", fm.out_valid, 0);
        check("midrst_r",     fm.out_r,     0);
        check("midrst_idx",   fm.out_idx,   0);
        check("midrst_last",  fm.out_last,  0);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_ready", fm.in_ready,  1);
        check("postrst_valid", fm.out_valid, 0);
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            ent_r[k] = OUT_W'(100 - k);
            ent_i[k] = OUT_W'(k);
        end
        fill_pass();
        send(1'b0);
        check("postrst_first_idx", fm.out_idx, 0);
        check("postrst_first_r",   fm.out_r,   100);
        drain(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
